mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of the EX/MEM pipeline register.
//  - Performs LW, SW and CALL return-address pushes against a variable-latency data memory (req/ack).
//  - Stalls the upstream pipeline while an access is outstanding.
//  - Registers the writeback result into the MEM/WB boundary.
//  - Non-memory instructions pass through with 1-cycle latency.
// PARAMETERS
//  DATA_W       16   data and address width (WISC 16-bit datapath)
//  RD_W         4    register-file destination index width
//  TIMEOUT_CYC  64   max WAIT cycles before the access is aborted (>=2)
// PORTS
//  clk            in   1       single clock, all state updates on posedge
//  rst_n          in   1       synchronous, active-low reset
//  regwrite_in    in   1       from EX/MEM: instruction writes regfile
//  memwrite_in    in   1       from EX/MEM: SW
//  memread_in     in   1       from EX/MEM: LW
//  call_in        in   1       from EX/MEM: CALL (push = memory write)
//  mem_to_reg_in  in   1       from EX/MEM: WB data comes from memory
//  reg_rd_in      in   RD_W    from EX/MEM: destination register
//  alu_result_in  in   DATA_W  from EX/MEM: ALU result / memory address
//  store_data_in  in   DATA_W  from EX/MEM: SW / CALL write data
//  ret_future_in  in   1       from EX/MEM: pipelined ret flag
//  stall_out      out  1       hold EX/MEM and earlier stages (combinational)
//  dmem_req       out  1       memory request, held until ack
//  dmem_we        out  1       1=write, 0=read
//  dmem_addr      out  DATA_W  memory address
//  dmem_wdata     out  DATA_W  memory write data
//  dmem_ack       in   1       memory completes the access this cycle
//  dmem_rdata     in   DATA_W  read data, valid when dmem_ack=1
//  wb_valid       out  1       MEM/WB holds a retired instruction
//  wb_regwrite    out  1       MEM/WB regfile write enable
//  wb_rd          out  RD_W    MEM/WB destination register
//  wb_data        out  DATA_W  MEM/WB writeback data
//  wb_ret         out  1       MEM/WB ret flag
//  mem_err        out  1       1-cycle pulse: access aborted on timeout
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; counter 0.
//    Reset mid-WAIT drops dmem_req on the next cycle; the access is abandoned and nothing is written back.
//  - access = memread_in | memwrite_in | call_in.
//    Write = memwrite_in | call_in; memread_in has lower priority if both are set.
//  - FSM states: IDLE, WAIT.
//  - IDLE, access=0:
//    - stall_out=0.
//    - Next edge: wb_* <= inputs, wb_data <= alu_result_in, wb_valid <= 1.
//  - IDLE, access=1:
//    - stall_out=1 and wb_valid <= 0 (bubble).
//    - Latch addr, wdata, we, rd, regwrite, mem_to_reg and ret into request registers.
//    - Go to WAIT; counter <= 0.
//  - WAIT:
//    - dmem_req=1; addr, wdata and we stay stable until ack.
//    - stall_out = ~dmem_ack.
//  - WAIT, dmem_ack=1:
//    - Go to IDLE.
//    - wb_data <= mem_to_reg ? dmem_rdata : latched addr; wb_valid <= 1.
//    - Upstream advances on the same edge.
//  - WAIT, no ack and counter == TIMEOUT_CYC-1:
//    - Go to IDLE; stall_out=0 in that cycle.
//    - mem_err pulses; wb_valid <= 1 with wb_regwrite <= 0.
//  - Latency: non-memory instruction 1 cycle. Memory access 2 + (cycles until ack) after presentation.
//    Minimum is 2, when ack arrives in the first WAIT cycle.
//  - dmem_ack while IDLE is ignored. dmem_ack on the timeout cycle counts as success (ack wins).
//  - Counter width is clog2(TIMEOUT_CYC) and it saturates; it never wraps.
//  - Upstream inputs must hold while stall_out=1; request registers make the stage tolerant if they do not.
// STRUCTURE
//  - mem_pkg: mem_state_e {IDLE, WAIT}, DATA_W and RD_W localparams, mem_req_t struct (addr, wdata, we, rd, regwrite, mem_to_reg, ret).
//  - One sub-module, mem_timeout_ctr: clear, enable, expired, saturating.
//  - FSM, request registers and MEM/WB registers stay in the top module.
// TESTING
//  - ALU op: regwrite=1, rd=3, alu=0x1234, no access -> next cycle wb_valid=1, wb_rd=3, wb_data=0x1234, stall 0.
//  - LW: addr 0x0040, ack 3 cycles after req with rdata=0xBEEF, rd=5
//    -> stall high 4 cycles, dmem_addr=0x0040 stable, wb_data=0xBEEF, wb_rd=5.
//  - SW/CALL: addr 0x00FE, data 0xCAFE, immediate ack -> dmem_we=1, dmem_wdata=0xCAFE, wb_regwrite=0, 2-cycle latency.
//  - Timeout: LW with no ack (TIMEOUT_CYC=64) -> req held 64 cycles, mem_err 1 pulse, wb_regwrite=0, then next instruction proceeds.
//  - Reset asserted in WAIT cycle 2 -> next cycle dmem_req=0, all wb_* 0, state IDLE; late ack ignored.
//  - Back-to-back LW, LW, ALU with ack latency 1 -> results retire in program order with no drop or duplicate.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the MEM pipeline stage: FSM states, datapath widths and the latched request.
// Request fields are captured once per access so the stage ignores upstream inputs while waiting.
package mem_pkg;
  localparam int DATA_W = 16;
  localparam int RD_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [RD_W-1:0]   rd;
    logic              regwrite;
    logic              mem_to_reg;
    logic              ret;
  } mem_req_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait counter: clear restarts at 0, enable counts up to MAX_CYC-1 and holds there.
// expired is combinational from the count; no backpressure, one increment per enabled cycle.
module mem_timeout_ctr #(
  parameter int MAX_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(MAX_CYC);
  localparam logic [CW-1:0] LAST = CW'(MAX_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: LW/SW/CALL against a req/ack data memory, result registered into MEM/WB.
// Latency 1 for non-memory ops, 2 + ack wait for accesses; stall_out holds upstream until ack or timeout.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite_in,
  input  logic              memwrite_in,
  input  logic              memread_in,
  input  logic              call_in,
  input  logic              mem_to_reg_in,
  input  logic [RD_W-1:0]   reg_rd_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              ret_future_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_ret,
  output logic              mem_err
);
  mem_state_e state, state_nxt;
  mem_req_t   req_q;
  logic       access;
  logic       expired;

  assign access = memread_in | memwrite_in | call_in;

  mem_timeout_ctr #(
    .MAX_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .enable  (state == WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ack takes precedence over expiry, so a response on the last wait cycle still succeeds.
  always_comb begin
    state_nxt = state;
    stall_out = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          stall_out = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        stall_out = ~(dmem_ack | expired);
        if (dmem_ack || expired) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q <= '0;
    end else if ((state == IDLE) && access) begin
      req_q.addr       <= alu_result_in;
      req_q.wdata      <= store_data_in;
      req_q.we         <= memwrite_in | call_in;
      req_q.rd         <= reg_rd_in;
      req_q.regwrite   <= regwrite_in;
      req_q.mem_to_reg <= mem_to_reg_in;
      req_q.ret        <= ret_future_in;
    end
  end

  assign dmem_req   = (state == WAIT);
  assign dmem_we    = req_q.we;
  assign dmem_addr  = req_q.addr;
  assign dmem_wdata = req_q.wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_ret      <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      if (state == IDLE) begin
        if (!access) begin
          wb_valid    <= 1'b1;
          wb_regwrite <= regwrite_in;
          wb_rd       <= reg_rd_in;
          wb_data     <= alu_result_in;
          wb_ret      <= ret_future_in;
        end else begin
          wb_valid    <= 1'b0;
          wb_regwrite <= 1'b0;
        end
      end else if (dmem_ack) begin
        wb_valid    <= 1'b1;
        wb_regwrite <= req_q.regwrite;
        wb_rd       <= req_q.rd;
        wb_data     <= req_q.mem_to_reg ? dmem_rdata : req_q.addr;
        wb_ret      <= req_q.ret;
      end else if (expired) begin
        // Aborted access still retires so the pipeline keeps order, but must not write the regfile.
        wb_valid    <= 1'b1;
        wb_regwrite <= 1'b0;
        wb_rd       <= req_q.rd;
        wb_data     <= req_q.addr;
        wb_ret      <= req_q.ret;
        mem_err     <= 1'b1;
      end else begin
        wb_valid    <= 1'b0;
        wb_regwrite <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: random instruction stream against a variable-latency memory,
// checked against an in-order program model of retirement, latency and stall counts.
module tb_mem_access_stage;
  localparam int TO     = 64;
  localparam int N_RAND = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regwrite_in, memwrite_in, memread_in, call_in, mem_to_reg_in, ret_future_in;
  logic [3:0]  reg_rd_in;
  logic [15:0] alu_result_in, store_data_in;
  logic        stall_out, dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, wb_regwrite, wb_ret, mem_err;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .regwrite_in(regwrite_in), .memwrite_in(memwrite_in), .memread_in(memread_in),
    .call_in(call_in), .mem_to_reg_in(mem_to_reg_in), .reg_rd_in(reg_rd_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .ret_future_in(ret_future_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_ret(wb_ret), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // lat: cycles the memory waits before acking; negative means it never acks.
  typedef struct { bit rw, mw, mr, call, m2r, ret; bit [3:0] rd; bit [15:0] alu, sd; int lat; } instr_t;
  typedef struct { bit rw; bit [3:0] rd; bit [15:0] data; bit ret, err; int issue, lat; } exp_t;
  typedef struct { bit [15:0] addr, wdata; bit we; int lat; } req_t;

  instr_t      prog[$];
  exp_t        expq[$];
  req_t        reqq[$];
  bit [15:0]   dmem [bit [15:0]];
  bit [15:0]   ref_mem [bit [15:0]];
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0;
  int          exp_stalls, stall_cnt, wcnt, pc, guard;
  bit          inflight, adv;
  req_t        cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit [15:0] init_val(input bit [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  function automatic instr_t nop();
    instr_t i;
    i.rw = 0; i.mw = 0; i.mr = 0; i.call = 0; i.m2r = 0; i.ret = 0;
    i.rd = 0; i.alu = 0; i.sd = 0; i.lat = 0;
    return i;
  endfunction

  function automatic instr_t mk(input bit rw, mw, mr, call, m2r, ret, input bit [3:0] rd,
                                input bit [15:0] alu, sd, input int lat);
    instr_t i;
    i.rw = rw; i.mw = mw; i.mr = mr; i.call = call; i.m2r = m2r; i.ret = ret;
    i.rd = rd; i.alu = alu; i.sd = sd; i.lat = lat;
    return i;
  endfunction

  // Program-order model: each instruction's retirement record, plus the memory request it should raise.
  function automatic void model_issue(input instr_t i);
    exp_t e; req_t r; bit [15:0] old;
    e.rw = i.rw; e.rd = i.rd; e.data = i.alu; e.ret = i.ret; e.err = 0;
    e.issue = cyc; e.lat = 1; exp_stalls = 0;
    if (i.mr | i.mw | i.call) begin
      r.addr = i.alu; r.wdata = i.sd; r.we = i.mw | i.call; r.lat = i.lat;
      reqq.push_back(r);
      if (i.lat < 0) begin
        e.rw = 0; e.err = 1; e.lat = TO + 1; exp_stalls = TO;
      end else begin
        old = ref_mem.exists(i.alu) ? ref_mem[i.alu] : init_val(i.alu);
        if (r.we) ref_mem[i.alu] = i.sd;
        if (i.m2r) e.data = old;
        e.lat = 2 + i.lat; exp_stalls = 1 + i.lat;
      end
    end
    expq.push_back(e);
  endfunction

  task automatic present(input instr_t i);
    regwrite_in = i.rw; memwrite_in = i.mw; memread_in = i.mr; call_in = i.call;
    mem_to_reg_in = i.m2r; ret_future_in = i.ret; reg_rd_in = i.rd;
    alu_result_in = i.alu; store_data_in = i.sd;
  endtask

  task automatic scramble();
    regwrite_in = 1'($urandom); memwrite_in = 1'($urandom); memread_in = 1'($urandom);
    call_in = 1'($urandom); mem_to_reg_in = 1'($urandom); ret_future_in = 1'($urandom);
    reg_rd_in = 4'($urandom); alu_result_in = 16'($urandom); store_data_in = 16'($urandom);
  endtask

  // Memory responder, evaluated mid-cycle; acks during IDLE are random noise the DUT must ignore.
  task automatic respond();
    if (dmem_req) begin
      if (!inflight) begin
        if (reqq.size() == 0) begin
          check("req_unexpected", dmem_req, 0);
          dmem_ack = 0;
          return;
        end
        cur = reqq.pop_front();
        inflight = 1; wcnt = 0;
      end
      check("dmem_addr", dmem_addr, cur.addr);
      check("dmem_we", dmem_we, cur.we);
      if (cur.we) check("dmem_wdata", dmem_wdata, cur.wdata);
      if (cur.lat >= 0 && wcnt == cur.lat) begin
        dmem_ack = 1;
        dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : init_val(dmem_addr);
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        inflight = 0;
      end else begin
        dmem_ack = 0;
        dmem_rdata = 16'($urandom);
      end
      wcnt++;
    end else begin
      if (inflight) begin
        check("timeout_req_cycles", wcnt, TO);
        inflight = 0;
      end
      dmem_ack = 1'($urandom);
      dmem_rdata = 16'($urandom);
    end
  endtask

  task automatic retire();
    exp_t e;
    if (!wb_valid) begin
      check("mem_err_idle", mem_err, 0);
      return;
    end
    if (expq.size() == 0) begin
      check("retire_unexpected", wb_valid, 0);
      return;
    end
    e = expq.pop_front();
    check("latency", cyc - e.issue, e.lat);
    check("wb_regwrite", wb_regwrite, e.rw);
    check("mem_err", mem_err, e.err);
    if (!e.err) begin
      check("wb_rd", wb_rd, e.rd);
      check("wb_data", wb_data, e.data);
      check("wb_ret", wb_ret, e.ret);
    end
  endtask

  initial begin
    rst_n = 0; present(nop()); dmem_ack = 0; dmem_rdata = 0; inflight = 0; wcnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", wb_valid, 0);   check("rst_wb_regwrite", wb_regwrite, 0);
    check("rst_wb_rd", wb_rd, 0);         check("rst_wb_data", wb_data, 0);
    check("rst_wb_ret", wb_ret, 0);       check("rst_mem_err", mem_err, 0);
    check("rst_dmem_req", dmem_req, 0);   check("rst_dmem_addr", dmem_addr, 0);
    check("rst_stall", stall_out, 0);

    dmem[16'h0040] = 16'hBEEF; ref_mem[16'h0040] = 16'hBEEF;
    prog.push_back(mk(1, 0, 0, 0, 0, 0, 4'd3,  16'h1234, 16'h0000, 0));  // ALU
    prog.push_back(mk(1, 0, 1, 0, 1, 0, 4'd5,  16'h0040, 16'h0000, 3));  // LW, ack after 3
    prog.push_back(mk(0, 1, 0, 0, 0, 0, 4'd0,  16'h00FE, 16'hCAFE, 0));  // SW, immediate ack
    prog.push_back(mk(1, 0, 0, 1, 0, 0, 4'd15, 16'h00FC, 16'h0102, 0));  // CALL push
    prog.push_back(mk(1, 0, 1, 0, 1, 0, 4'd6,  16'h0040, 16'h0000, -1)); // LW, no ack
    prog.push_back(mk(1, 0, 0, 0, 0, 1, 4'd1,  16'h5555, 16'h0000, 0));  // ALU with ret
    prog.push_back(mk(1, 0, 1, 0, 1, 0, 4'd7,  16'h00FE, 16'h0000, 1));  // LW, LW, ALU
    prog.push_back(mk(1, 0, 1, 0, 1, 0, 4'd8,  16'h00FC, 16'h0000, 1));
    prog.push_back(mk(1, 0, 0, 0, 0, 0, 4'd9,  16'hA5A5, 16'h0000, 0));
    prog.push_back(mk(1, 0, 1, 0, 1, 0, 4'd2,  16'h0040, 16'h0000, TO - 1)); // ack on last wait cycle
    prog.push_back(mk(1, 1, 1, 0, 0, 0, 4'd4,  16'h0010, 16'h7777, 0));  // read+write: write wins
    prog.push_back(mk(1, 0, 1, 0, 1, 0, 4'd4,  16'h0010, 16'h0000, 0));
    for (int k = 0; k < N_RAND; k++) begin
      instr_t i; int kind, r, lat;
      kind = int'($urandom_range(0, 9));
      r = int'($urandom_range(0, 99));
      lat = (r < 4) ? -1 : (r < 6) ? TO - 1 : int'($urandom_range(0, 3));
      i = nop();
      i.rd = 4'($urandom); i.ret = ($urandom_range(0, 7) == 0);
      i.sd = 16'($urandom); i.lat = lat;
      if (kind <= 3) begin
        i.rw = 1'($urandom); i.alu = 16'($urandom);
      end else begin
        i.alu = 16'($urandom_range(0, 15) << 1);
        case (kind)
          4, 5: begin i.mr = 1; i.m2r = 1; i.rw = 1; end
          6: i.mw = 1;
          7: begin i.call = 1; i.rw = 1'($urandom); end
          8: begin i.mr = 1; i.mw = 1; i.rw = 1'($urandom); end
          default: begin i.mr = 1; i.m2r = 1'($urandom); i.rw = 1'($urandom); end
        endcase
      end
      prog.push_back(i);
    end
    prog.push_back(nop());

    @(posedge clk); #1;
    rst_n = 1;
    pc = 0; stall_cnt = 0; guard = 0;
    present(prog[0]); model_issue(prog[0]);
    while (pc < prog.size() && guard < 40000) begin
      @(negedge clk);
      respond();
      #1;
      retire();
      adv = !stall_out;
      if (stall_out) stall_cnt++;
      @(posedge clk); #1;
      guard++;
      if (adv) begin
        check("stall_cycles", stall_cnt, exp_stalls);
        pc++; stall_cnt = 0;
        if (pc < prog.size()) begin
          present(prog[pc]); model_issue(prog[pc]);
        end
      end else begin
        scramble();
      end
    end
    check("all_issued", pc, prog.size());
    @(negedge clk);
    respond();
    #1;
    retire();
    check("drain", expq.size(), 0);

    // Reset during the second wait cycle abandons the access; a late ack must not leak through.
    @(posedge clk); #1;
    dmem_ack = 0;
    present(mk(1, 0, 1, 0, 1, 0, 4'd7, 16'h0100, 16'h0000, 10));
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wait_req", dmem_req, 1);
    @(posedge clk); #1;
    dmem_ack = 0;
    check("rst_wait_stall", stall_out, 1);
    rst_n = 0; present(nop());
    @(posedge clk); @(negedge clk);
    check("rst_mid_req", dmem_req, 0);     check("rst_mid_valid", wb_valid, 0);
    check("rst_mid_regwrite", wb_regwrite, 0); check("rst_mid_rd", wb_rd, 0);
    check("rst_mid_data", wb_data, 0);     check("rst_mid_ret", wb_ret, 0);
    check("rst_mid_err", mem_err, 0);      check("rst_mid_stall", stall_out, 0);
    dmem_ack = 1; dmem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); @(negedge clk);
    check("late_ack_req", dmem_req, 0);    check("late_ack_valid", wb_valid, 1);
    check("late_ack_data", wb_data, 0);    check("late_ack_regwrite", wb_regwrite, 0);
    check("late_ack_err", mem_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
